// File: rtl/sdram_port_arbiter_if.sv
// SDRAM port arbiter bus bundle.
// Groups the three signal families the arbiter sits between:
//   hw_*  : buffered write port (valid/ready, address, data)
//   dr_*  : display burst-read port (start, address, length, data/valid/done/busy)
//   c_*   : SDRAM controller side (read/write enables, addresses, data, acks, busy)
// Modports:
//   slave  : the arbiter's view (consumes client requests and controller acks)
//   master : the environment's view (write client, display client and controller)
interface sdram_port_arbiter_if #(
    parameter int unsigned HADDR_WIDTH = 22
);
    // Write port
    logic                   hw_valid;
    logic [HADDR_WIDTH-1:0] hw_addr;
    logic [15:0]            hw_data;
    logic                   hw_ready;

    // Display read port
    logic                   dr_start;
    logic [HADDR_WIDTH-1:0] dr_addr;
    logic [7:0]             dr_len;
    logic [15:0]            dr_data;
    logic                   dr_valid;
    logic                   dr_done;
    logic                   dr_busy;

    // Controller side
    logic [HADDR_WIDTH-1:0] c_wr_addr;
    logic [15:0]            c_wr_data;
    logic                   c_wr_enable;
    logic [HADDR_WIDTH-1:0] c_rd_addr;
    logic                   c_rd_enable;
    logic                   c_wr_addr_inc;
    logic [15:0]            c_rd_data;
    logic                   c_rd_ready;
    logic                   c_busy;

    modport slave (
        input  hw_valid, hw_addr, hw_data,
        input  dr_start, dr_addr, dr_len,
        input  c_wr_addr_inc, c_rd_data, c_rd_ready, c_busy,
        output hw_ready,
        output dr_data, dr_valid, dr_done, dr_busy,
        output c_wr_addr, c_wr_data, c_wr_enable, c_rd_addr, c_rd_enable
    );

    modport master (
        output hw_valid, hw_addr, hw_data,
        output dr_start, dr_addr, dr_len,
        output c_wr_addr_inc, c_rd_data, c_rd_ready, c_busy,
        input  hw_ready,
        input  dr_data, dr_valid, dr_done, dr_busy,
        input  c_wr_addr, c_wr_data, c_wr_enable, c_rd_addr, c_rd_enable
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// SDRAM port arbiter.
// Shares one SDRAM controller between a buffered write port and a display
// burst-read port. Writes are queued in a small FIFO; display bursts are issued
// one word at a time. Reads normally win, but after STARVE_LIMIT consecutive
// read grants with writes waiting, one write is forced through between words.
// Every controller transaction is followed by a single-cycle gap.
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus        : sdram_port_arbiter_if.slave (write port, display port, controller)
// All outputs are registered except bus.hw_ready (= FIFO not full).
// WFIFO_DEPTH must be a power of two and at least 2.
module sdram_port_arbiter #(
    parameter int unsigned HADDR_WIDTH  = 22,
    parameter int unsigned WFIFO_DEPTH  = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    sdram_port_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_RD,
        ARB_WR,
        ARB_GAP
    } arb_state_e;

    arb_state_e state_q, state_d;

    // Write FIFO
    logic [HADDR_WIDTH-1:0] fifo_addr_mem [WFIFO_DEPTH];
    logic [15:0]            fifo_data_mem [WFIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]       fifo_cnt_q, fifo_cnt_d;
    logic                   fifo_empty, fifo_full, push, pop;

    // Arbitration
    logic [STV_W-1:0] starve_q, starve_d;
    logic             starved, idle_ok, rd_grant, wr_grant, rd_word_done;

    // Display burst tracking
    logic [HADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [8:0]             rd_cnt_q, rd_cnt_d;
    logic                   dr_busy_q, dr_busy_d;

    // Registered outputs
    logic                   c_rd_enable_q, c_rd_enable_d;
    logic [HADDR_WIDTH-1:0] c_rd_addr_q, c_rd_addr_d;
    logic                   c_wr_enable_q, c_wr_enable_d;
    logic [HADDR_WIDTH-1:0] c_wr_addr_q, c_wr_addr_d;
    logic [15:0]            c_wr_data_q, c_wr_data_d;
    logic [15:0]            dr_data_q, dr_data_d;
    logic                   dr_valid_q, dr_valid_d;
    logic                   dr_done_q, dr_done_d;

    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_full  = (fifo_cnt_q == CNT_W'(WFIFO_DEPTH));
    // Push is gated by the registered full flag, so a same-cycle pop cannot
    // make room for a push while full.
    assign push       = bus.hw_valid && !fifo_full;
    assign pop        = (state_q == ARB_WR) && bus.c_wr_addr_inc;

    assign starved      = !fifo_empty && (starve_q >= STV_W'(STARVE_LIMIT));
    assign idle_ok      = (state_q == ARB_IDLE) && !bus.c_busy;
    // dr_busy_q means a burst word is still owed; in ARB_IDLE none is in flight.
    assign rd_grant     = idle_ok && dr_busy_q && !starved;
    assign wr_grant     = idle_ok && !rd_grant && !fifo_empty;
    assign rd_word_done = (state_q == ARB_RD) && bus.c_rd_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (rd_grant) begin
                    state_d = ARB_RD;
                end else if (wr_grant) begin
                    state_d = ARB_WR;
                end
            end
            ARB_RD:  if (bus.c_rd_ready) state_d = ARB_GAP;
            ARB_WR:  if (bus.c_wr_addr_inc) state_d = ARB_GAP;
            ARB_GAP: state_d = ARB_IDLE;
        endcase
    end

    // ---------------- FSM: outputs and datapath next values ----------------
    always_comb begin
        c_rd_enable_d = c_rd_enable_q;
        c_rd_addr_d   = c_rd_addr_q;
        c_wr_enable_d = c_wr_enable_q;
        c_wr_addr_d   = c_wr_addr_q;
        c_wr_data_d   = c_wr_data_q;
        dr_data_d     = dr_data_q;
        dr_valid_d    = 1'b0;
        dr_done_d     = 1'b0;
        rd_addr_d     = rd_addr_q;
        rd_cnt_d      = rd_cnt_q;
        dr_busy_d     = dr_busy_q;
        starve_d      = starve_q;

        if (rd_grant) begin
            c_rd_enable_d = 1'b1;
            c_rd_addr_d   = rd_addr_q;
        end
        if (rd_word_done) begin
            c_rd_enable_d = 1'b0;
            dr_data_d     = bus.c_rd_data;
            dr_valid_d    = 1'b1;
            rd_addr_d     = rd_addr_q + HADDR_WIDTH'(1);
            rd_cnt_d      = rd_cnt_q - 9'd1;
            if (rd_cnt_q == 9'd1) begin
                dr_done_d = 1'b1;
                dr_busy_d = 1'b0;
            end
        end

        if (wr_grant) begin
            c_wr_enable_d = 1'b1;
            c_wr_addr_d   = fifo_addr_mem[rd_ptr_q];
            c_wr_data_d   = fifo_data_mem[rd_ptr_q];
        end
        if (pop) begin
            c_wr_enable_d = 1'b0;
        end

        // A new burst can only be accepted when no burst is active, so this
        // never collides with rd_word_done above.
        if (bus.dr_start && !dr_busy_q) begin
            dr_busy_d = 1'b1;
            rd_addr_d = bus.dr_addr;
            rd_cnt_d  = (bus.dr_len == 8'd0) ? 9'd256 : {1'b0, bus.dr_len};
        end

        if (wr_grant || fifo_empty) begin
            starve_d = '0;
        end else if (rd_grant && (starve_q < STV_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + STV_W'(1);
        end
    end

    // FIFO occupancy
    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        unique case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // FIFO storage needs no reset: entries are only read when counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_mem[wr_ptr_q] <= bus.hw_addr;
            fifo_data_mem[wr_ptr_q] <= bus.hw_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
            starve_q      <= '0;
            rd_addr_q     <= '0;
            rd_cnt_q      <= '0;
            dr_busy_q     <= 1'b0;
            c_rd_enable_q <= 1'b0;
            c_rd_addr_q   <= '0;
            c_wr_enable_q <= 1'b0;
            c_wr_addr_q   <= '0;
            c_wr_data_q   <= '0;
            dr_data_q     <= '0;
            dr_valid_q    <= 1'b0;
            dr_done_q     <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            fifo_cnt_q    <= fifo_cnt_d;
            starve_q      <= starve_d;
            rd_addr_q     <= rd_addr_d;
            rd_cnt_q      <= rd_cnt_d;
            dr_busy_q     <= dr_busy_d;
            c_rd_enable_q <= c_rd_enable_d;
            c_rd_addr_q   <= c_rd_addr_d;
            c_wr_enable_q <= c_wr_enable_d;
            c_wr_addr_q   <= c_wr_addr_d;
            c_wr_data_q   <= c_wr_data_d;
            dr_data_q     <= dr_data_d;
            dr_valid_q    <= dr_valid_d;
            dr_done_q     <= dr_done_d;
        end
    end

    assign bus.hw_ready    = !fifo_full;
    assign bus.dr_data     = dr_data_q;
    assign bus.dr_valid    = dr_valid_q;
    assign bus.dr_done     = dr_done_q;
    assign bus.dr_busy     = dr_busy_q;
    assign bus.c_wr_addr   = c_wr_addr_q;
    assign bus.c_wr_data   = c_wr_data_q;
    assign bus.c_wr_enable = c_wr_enable_q;
    assign bus.c_rd_addr   = c_rd_addr_q;
    assign bus.c_rd_enable = c_rd_enable_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed testbench for sdram_port_arbiter (default parameters).
module tb_sdram_port_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    sdram_port_arbiter_if #(.HADDR_WIDTH(22)) bus ();

    sdram_port_arbiter #(
        .HADDR_WIDTH (22),
        .WFIFO_DEPTH (4),
        .STARVE_LIMIT(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Read and write enables must never overlap.
    always @(negedge clk) begin
        if (rst_n && bus.c_rd_enable && bus.c_wr_enable) begin
            errors++;
            $display("FAIL enable_overlap: rd_en=%0b wr_en=%0b, required not both", 
                     bus.c_rd_enable, bus.c_wr_enable);
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Respond to the next read request; returns the address it was issued at.
    task automatic serve_rd(input logic [15:0] data, output logic [21:0] addr, output bit ok);
        ok   = 1'b0;
        addr = '0;
        for (int i = 0; i < 64 && !ok; i++) begin
            if (bus.c_rd_enable) begin
                addr           = bus.c_rd_addr;
                bus.c_rd_data  = data;
                bus.c_rd_ready = 1'b1;
                tick();
                bus.c_rd_ready = 1'b0;
                ok             = 1'b1;
            end else begin
                tick();
            end
        end
    endtask

    // Acknowledge the next write request; returns its address and data.
    task automatic serve_wr(output logic [21:0] addr, output logic [15:0] data, output bit ok);
        ok   = 1'b0;
        addr = '0;
        data = '0;
        for (int i = 0; i < 64 && !ok; i++) begin
            if (bus.c_wr_enable) begin
                addr              = bus.c_wr_addr;
                data              = bus.c_wr_data;
                bus.c_wr_addr_inc = 1'b1;
                tick();
                bus.c_wr_addr_inc = 1'b0;
                ok                = 1'b1;
            end else begin
                tick();
            end
        end
    endtask

    task automatic test_reset();
        rst_n             = 1'b0;
        bus.hw_valid      = 1'b0;
        bus.hw_addr       = '0;
        bus.hw_data       = '0;
        bus.dr_start      = 1'b0;
        bus.dr_addr       = '0;
        bus.dr_len        = '0;
        bus.c_wr_addr_inc = 1'b0;
        bus.c_rd_data     = '0;
        bus.c_rd_ready    = 1'b0;
        bus.c_busy        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.c_rd_enable !== 1'b0) begin errors++; $display("FAIL rst_c_rd_enable: got %b want 0", bus.c_rd_enable); end
        checks++; if (bus.c_wr_enable !== 1'b0) begin errors++; $display("FAIL rst_c_wr_enable: got %b want 0", bus.c_wr_enable); end
        checks++; if (bus.c_wr_addr !== 22'h0) begin errors++; $display("FAIL rst_c_wr_addr: got %h want 0", bus.c_wr_addr); end
        checks++; if (bus.c_wr_data !== 16'h0) begin errors++; $display("FAIL rst_c_wr_data: got %h want 0", bus.c_wr_data); end
        checks++; if (bus.c_rd_addr !== 22'h0) begin errors++; $display("FAIL rst_c_rd_addr: got %h want 0", bus.c_rd_addr); end
        checks++; if (bus.dr_data !== 16'h0) begin errors++; $display("FAIL rst_dr_data: got %h want 0", bus.dr_data); end
        checks++; if (bus.dr_valid !== 1'b0) begin errors++; $display("FAIL rst_dr_valid: got %b want 0", bus.dr_valid); end
        checks++; if (bus.dr_done !== 1'b0) begin errors++; $display("FAIL rst_dr_done: got %b want 0", bus.dr_done); end
        checks++; if (bus.dr_busy !== 1'b0) begin errors++; $display("FAIL rst_dr_busy: got %b want 0", bus.dr_busy); end
        checks++; if (bus.hw_ready !== 1'b1) begin errors++; $display("FAIL rst_hw_ready: got %b want 1", bus.hw_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        logic [21:0] a;
        bit          ok;
        bus.dr_addr  = 22'h000100;
        bus.dr_len   = 8'd1;
        bus.dr_start = 1'b1;
        tick();
        bus.dr_start = 1'b0;
        checks++; if (bus.dr_busy !== 1'b1) begin errors++; $display("FAIL single_busy_set: got %b want 1", bus.dr_busy); end
        checks++; if (bus.c_rd_enable !== 1'b0) begin errors++; $display("FAIL single_rd_en_early: got %b want 0", bus.c_rd_enable); end
        tick();
        checks++; if (bus.c_rd_enable !== 1'b1) begin errors++; $display("FAIL single_rd_en_latency: got %b want 1", bus.c_rd_enable); end
        checks++; if (bus.c_rd_addr !== 22'h000100) begin errors++; $display("FAIL single_rd_addr: got %h want 000100", bus.c_rd_addr); end
        tick();
        tick();
        checks++; if ({bus.c_rd_enable, bus.c_rd_addr} !== {1'b1, 22'h000100}) begin errors++; $display("FAIL single_rd_hold: got en=%b addr=%h want en=1 addr=000100", bus.c_rd_enable, bus.c_rd_addr); end
        serve_rd(16'hBEEF, a, ok);
        checks++; if (!ok || a !== 22'h000100) begin errors++; $display("FAIL single_served: ok=%0b addr=%h want ok=1 addr=000100", ok, a); end
        checks++; if (bus.dr_valid !== 1'b1) begin errors++; $display("FAIL single_dr_valid: got %b want 1", bus.dr_valid); end
        checks++; if (bus.dr_done !== 1'b1) begin errors++; $display("FAIL single_dr_done: got %b want 1", bus.dr_done); end
        checks++; if (bus.dr_data !== 16'hBEEF) begin errors++; $display("FAIL single_dr_data: got %h want beef", bus.dr_data); end
        checks++; if (bus.dr_busy !== 1'b0) begin errors++; $display("FAIL single_busy_clear: got %b want 0", bus.dr_busy); end
        checks++; if (bus.c_rd_enable !== 1'b0) begin errors++; $display("FAIL single_rd_en_clear: got %b want 0", bus.c_rd_enable); end
        tick();
        checks++; if ({bus.dr_valid, bus.dr_done} !== 2'b00) begin errors++; $display("FAIL single_pulse_len: got valid=%b done=%b want 0 0", bus.dr_valid, bus.dr_done); end
        begin
            int extra = 0;
            repeat (5) begin
                tick();
                if (bus.c_rd_enable || bus.dr_valid) extra++;
            end
            checks++; if (extra !== 0) begin errors++; $display("FAIL single_no_extra: got %0d extra cycles want 0", extra); end
        end
    endtask

    task automatic test_burst_wrap();
        logic [21:0] exp_addr [4];
        logic [21:0] a;
        bit          ok;
        exp_addr[0] = 22'h3FFFFE;
        exp_addr[1] = 22'h3FFFFF;
        exp_addr[2] = 22'h000000;
        exp_addr[3] = 22'h000001;
        bus.dr_addr  = 22'h3FFFFE;
        bus.dr_len   = 8'd4;
        bus.dr_start = 1'b1;
        tick();
        bus.dr_start = 1'b0;
        for (int w = 0; w < 4; w++) begin
            serve_rd(16'h1000 + 16'(w), a, ok);
            checks++; if (!ok || a !== exp_addr[w]) begin errors++; $display("FAIL burst_addr%0d: ok=%0b got %h want %h", w, ok, a, exp_addr[w]); end
            checks++; if (bus.dr_valid !== 1'b1 || bus.dr_data !== 16'h1000 + 16'(w)) begin errors++; $display("FAIL burst_data%0d: valid=%b data=%h want 1 %h", w, bus.dr_valid, bus.dr_data, 16'h1000 + 16'(w)); end
            checks++; if (bus.dr_done !== (w == 3)) begin errors++; $display("FAIL burst_done%0d: got %b want %b", w, bus.dr_done, (w == 3)); end
            checks++; if (bus.dr_busy !== (w != 3)) begin errors++; $display("FAIL burst_busy%0d: got %b want %b", w, bus.dr_busy, (w != 3)); end
        end
    endtask

    task automatic test_fifo_full();
        logic [21:0] a;
        logic [15:0] d;
        bit          ok;
        for (int k = 0; k < 4; k++) begin
            bus.hw_valid = 1'b1;
            bus.hw_addr  = 22'h010000 + 22'(k);
            bus.hw_data  = 16'hA000 + 16'(k);
            checks++; if (bus.hw_ready !== 1'b1) begin errors++; $display("FAIL full_ready%0d: got %b want 1", k, bus.hw_ready); end
            tick();
        end
        bus.hw_addr = 22'h010004;
        bus.hw_data = 16'hA004;
        checks++; if (bus.hw_ready !== 1'b0) begin errors++; $display("FAIL full_not_ready: got %b want 0", bus.hw_ready); end
        checks++; if ({bus.c_wr_enable, bus.c_wr_addr, bus.c_wr_data} !== {1'b1, 22'h010000, 16'hA000}) begin errors++; $display("FAIL full_first_wr: en=%b addr=%h data=%h want 1 010000 a000", bus.c_wr_enable, bus.c_wr_addr, bus.c_wr_data); end
        repeat (3) tick();
        checks++; if (bus.hw_ready !== 1'b0) begin errors++; $display("FAIL full_hold_ready: got %b want 0", bus.hw_ready); end
        checks++; if (bus.c_wr_enable !== 1'b1) begin errors++; $display("FAIL full_hold_wr_en: got %b want 1", bus.c_wr_enable); end
        bus.c_wr_addr_inc = 1'b1;
        tick();
        bus.c_wr_addr_inc = 1'b0;
        checks++; if (bus.hw_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop: got %b want 1", bus.hw_ready); end
        checks++; if (bus.c_wr_enable !== 1'b0) begin errors++; $display("FAIL full_wr_en_clear: got %b want 0", bus.c_wr_enable); end
        tick();
        bus.hw_valid = 1'b0;
        checks++; if (bus.hw_ready !== 1'b0) begin errors++; $display("FAIL full_fifth_taken: got ready=%b want 0", bus.hw_ready); end
        for (int k = 1; k < 5; k++) begin
            serve_wr(a, d, ok);
            checks++; if (!ok || a !== 22'h010000 + 22'(k) || d !== 16'hA000 + 16'(k)) begin errors++; $display("FAIL full_drain%0d: ok=%0b addr=%h data=%h want %h %h", k, ok, a, d, 22'h010000 + 22'(k), 16'hA000 + 16'(k)); end
        end
        repeat (3) tick();
        checks++; if (bus.c_wr_enable !== 1'b0 || bus.hw_ready !== 1'b1) begin errors++; $display("FAIL full_empty_after: wr_en=%b ready=%b want 0 1", bus.c_wr_enable, bus.hw_ready); end
    endtask

    task automatic test_starvation();
        int          nreads = 0;
        int          reads_before = -1;
        int          addr_bad = 0;
        int          done_early = 0;
        int          nwrites = 0;
        bit          last_done = 1'b0;
        logic [21:0] exp_addr = 22'h000200;
        logic [21:0] wa = '0;
        bus.c_busy   = 1'b1;
        bus.hw_valid = 1'b1;
        bus.hw_addr  = 22'h020000;
        bus.hw_data  = 16'h5A5A;
        tick();
        bus.hw_valid = 1'b0;
        bus.dr_addr  = 22'h000200;
        bus.dr_len   = 8'd0;
        bus.dr_start = 1'b1;
        tick();
        bus.dr_start = 1'b0;
        checks++; if (bus.dr_busy !== 1'b1 || bus.c_rd_enable !== 1'b0) begin errors++; $display("FAIL starve_setup: busy=%b rd_en=%b want 1 0", bus.dr_busy, bus.c_rd_enable); end
        bus.c_busy = 1'b0;
        for (int cyc = 0; cyc < 3000 && nreads < 256; cyc++) begin
            if (bus.c_wr_enable) begin
                if (nwrites == 0) reads_before = nreads;
                nwrites++;
                wa = bus.c_wr_addr;
                bus.c_wr_addr_inc = 1'b1;
                tick();
                bus.c_wr_addr_inc = 1'b0;
            end else if (bus.c_rd_enable) begin
                if (bus.c_rd_addr !== exp_addr) begin
                    addr_bad++;
                    $display("FAIL starve_addr%0d: got %h want %h", nreads, bus.c_rd_addr, exp_addr);
                end
                bus.c_rd_data  = 16'(nreads);
                bus.c_rd_ready = 1'b1;
                tick();
                bus.c_rd_ready = 1'b0;
                nreads++;
                exp_addr = exp_addr + 22'd1;
                if (nreads < 256 && bus.dr_done) done_early++;
                if (nreads == 256) last_done = bus.dr_done;
            end else begin
                tick();
            end
        end
        checks++; if (nreads !== 256) begin errors++; $display("FAIL starve_read_count: got %0d want 256", nreads); end
        checks++; if (nwrites !== 1) begin errors++; $display("FAIL starve_write_count: got %0d want 1", nwrites); end
        checks++; if (reads_before !== 8) begin errors++; $display("FAIL starve_grant_point: got %0d reads before write want 8", reads_before); end
        checks++; if (wa !== 22'h020000) begin errors++; $display("FAIL starve_wr_addr: got %h want 020000", wa); end
        checks++; if (addr_bad !== 0) begin errors++; $display("FAIL starve_contiguous: got %0d bad addresses want 0", addr_bad); end
        checks++; if (done_early !== 0 || last_done !== 1'b1) begin errors++; $display("FAIL starve_done: early=%0d last=%b want 0 1", done_early, last_done); end
        checks++; if (bus.dr_busy !== 1'b0) begin errors++; $display("FAIL starve_busy_end: got %b want 0", bus.dr_busy); end
        repeat (2) tick();
    endtask

    task automatic test_busy_hold();
        logic [21:0] a;
        logic [15:0] d;
        bit          ok;
        int          viol = 0;
        bus.c_busy   = 1'b1;
        bus.hw_valid = 1'b1;
        bus.hw_addr  = 22'h030000;
        bus.hw_data  = 16'h7777;
        tick();
        bus.hw_valid = 1'b0;
        bus.dr_addr  = 22'h000400;
        bus.dr_len   = 8'd1;
        bus.dr_start = 1'b1;
        tick();
        bus.dr_start = 1'b0;
        repeat (20) begin
            tick();
            if (bus.c_rd_enable || bus.c_wr_enable) viol++;
        end
        checks++; if (viol !== 0) begin errors++; $display("FAIL busy_no_enable: got %0d enabled cycles want 0", viol); end
        bus.c_busy = 1'b0;
        tick();
        checks++; if (bus.c_rd_enable !== 1'b1 || bus.c_wr_enable !== 1'b0) begin errors++; $display("FAIL busy_read_first: rd_en=%b wr_en=%b want 1 0", bus.c_rd_enable, bus.c_wr_enable); end
        serve_rd(16'h4444, a, ok);
        checks++; if (!ok || a !== 22'h000400 || bus.dr_done !== 1'b1) begin errors++; $display("FAIL busy_read: ok=%0b addr=%h done=%b want 1 000400 1", ok, a, bus.dr_done); end
        serve_wr(a, d, ok);
        checks++; if (!ok || a !== 22'h030000 || d !== 16'h7777) begin errors++; $display("FAIL busy_write: ok=%0b addr=%h data=%h want 1 030000 7777", ok, a, d); end
        repeat (2) tick();
    endtask

    task automatic test_reset_mid_write();
        int bad = 0;
        bus.hw_valid = 1'b1;
        bus.hw_addr  = 22'h040000;
        bus.hw_data  = 16'h1234;
        tick();
        bus.hw_valid = 1'b0;
        tick();
        checks++; if (bus.c_wr_enable !== 1'b1) begin errors++; $display("FAIL rstwr_in_wr: got %b want 1", bus.c_wr_enable); end
        bus.dr_addr  = 22'h000500;
        bus.dr_len   = 8'd4;
        bus.dr_start = 1'b1;
        tick();
        bus.dr_start = 1'b0;
        bus.hw_valid = 1'b1;
        bus.hw_addr  = 22'h040001;
        tick();
        bus.hw_valid = 1'b0;
        checks++; if (bus.dr_busy !== 1'b1 || bus.c_wr_enable !== 1'b1) begin errors++; $display("FAIL rstwr_setup: busy=%b wr_en=%b want 1 1", bus.dr_busy, bus.c_wr_enable); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.c_wr_enable !== 1'b0) begin errors++; $display("FAIL rstwr_async_wr_en: got %b want 0", bus.c_wr_enable); end
        checks++; if (bus.hw_ready !== 1'b1) begin errors++; $display("FAIL rstwr_hw_ready: got %b want 1", bus.hw_ready); end
        checks++; if (bus.dr_busy !== 1'b0) begin errors++; $display("FAIL rstwr_dr_busy: got %b want 0", bus.dr_busy); end
        tick();
        rst_n = 1'b1;
        repeat (10) begin
            tick();
            if (bus.dr_valid || bus.dr_done || bus.c_wr_enable || bus.c_rd_enable || !bus.hw_ready) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rstwr_quiet_after: got %0d active cycles want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_burst_wrap();
        test_fifo_full();
        test_starvation();
        test_busy_hold();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
